// File: rtl/adc_spi_frame_sequencer.sv
// Master-side SPI frame engine for the serial ADC (io_clk domain).
// Drives sck_o/cs_n_o from flops, shifts one FRAME_BITS frame MSB first,
// and presents the low DW bits with a one-cycle valid and leading-bit error flag.
module adc_spi_frame_sequencer #(
    parameter int FRAME_BITS   = 14,
    parameter int DW           = 12,
    parameter int CS_SETUP_CYC = 1,
    parameter int QUIET_CYC    = 2
) (
    input  logic          io_clk,
    input  logic          rst,
    input  logic          en,
    input  logic          sdata,
    output logic          sck_o,
    output logic          cs_n_o,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          frame_err_o
);

    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int SW = (CS_SETUP_CYC > 1) ? $clog2(CS_SETUP_CYC) : 1;
    localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);
    localparam logic [SW-1:0] SETUP_LAST = SW'(CS_SETUP_CYC - 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        QUIET
    } state_t;

    state_t                state, state_nxt;
    logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
    logic                  phase, phase_nxt;
    logic [SW-1:0]         setup_cnt, setup_cnt_nxt;
    logic [QW-1:0]         quiet_cnt, quiet_cnt_nxt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  sck_nxt;
    logic                  cs_n_nxt;
    logic                  shift_en;
    logic                  load_out;

    // Next-state, counter and pin-level decode; pins are registered from these values
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        phase_nxt     = phase;
        setup_cnt_nxt = setup_cnt;
        quiet_cnt_nxt = quiet_cnt;
        sck_nxt       = 1'b1;
        cs_n_nxt      = 1'b1;
        shift_en      = 1'b0;
        load_out      = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt     = SETUP;
                    setup_cnt_nxt = '0;
                    cs_n_nxt      = 1'b0;
                end
            end

            SETUP: begin
                cs_n_nxt = 1'b0;
                if (setup_cnt == SETUP_LAST) begin
                    state_nxt   = SHIFT;
                    bit_cnt_nxt = '0;
                    phase_nxt   = 1'b0;
                    sck_nxt     = 1'b0;
                end else begin
                    setup_cnt_nxt = setup_cnt + SW'(1);
                end
            end

            SHIFT: begin
                cs_n_nxt = 1'b0;
                if (!phase) begin
                    // sck rising edge: the ADC bit is captured here
                    phase_nxt = 1'b1;
                    sck_nxt   = 1'b1;
                    shift_en  = 1'b1;
                end else if (bit_cnt == BIT_LAST) begin
                    state_nxt     = QUIET;
                    quiet_cnt_nxt = '0;
                    cs_n_nxt      = 1'b1;
                    load_out      = 1'b1;
                end else begin
                    bit_cnt_nxt = bit_cnt + BW'(1);
                    phase_nxt   = 1'b0;
                    sck_nxt     = 1'b0;
                end
            end

            QUIET: begin
                if (quiet_cnt == QUIET_LAST) begin
                    if (en) begin
                        state_nxt     = SETUP;
                        setup_cnt_nxt = '0;
                        cs_n_nxt      = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    quiet_cnt_nxt = quiet_cnt + QW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered SPI pins
    always_ff @(posedge io_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            phase     <= 1'b0;
            setup_cnt <= '0;
            quiet_cnt <= '0;
            sck_o     <= 1'b1;
            cs_n_o    <= 1'b1;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            phase     <= phase_nxt;
            setup_cnt <= setup_cnt_nxt;
            quiet_cnt <= quiet_cnt_nxt;
            sck_o     <= sck_nxt;
            cs_n_o    <= cs_n_nxt;
        end
    end

    // Serial capture shift register, MSB of the frame arrives first
    always_ff @(posedge io_clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {shreg[FRAME_BITS-2:0], sdata};
        end
    end

    // Output word, valid pulse and leading-bit check on entry to QUIET
    always_ff @(posedge io_clk or posedge rst) begin
        if (rst) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            valid_o     <= load_out;
            frame_err_o <= load_out & (|shreg[FRAME_BITS-1:DW]);
            if (load_out) begin
                data_o <= shreg[DW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_frame_sequencer.sv
// Directed bench for adc_spi_frame_sequencer with a behavioural ADC model.
module tb_adc_spi_frame_sequencer;

    logic        io_clk;
    logic        rst;
    logic        en;
    logic        sdata;
    logic        sck_o;
    logic        cs_n_o;
    logic [11:0] data_o;
    logic        valid_o;
    logic        frame_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    adc_spi_frame_sequencer #(
        .FRAME_BITS  (14),
        .DW          (12),
        .CS_SETUP_CYC(1),
        .QUIET_CYC   (2)
    ) dut (
        .io_clk     (io_clk),
        .rst        (rst),
        .en         (en),
        .sdata      (sdata),
        .sck_o      (sck_o),
        .cs_n_o     (cs_n_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_err_o(frame_err_o)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    always @(posedge io_clk) cyc <= cyc + 1;

    // ADC model: each frame pops a 14-bit word, MSB first, advancing after each sck rise
    logic [13:0] words[$];
    logic [13:0] cur_word = '0;
    int          idx = 14;

    always @(negedge cs_n_o) begin
        idx = 0;
        cur_word = (words.size() > 0) ? words.pop_front() : 14'h0;
    end

    always @(posedge sck_o) if (!cs_n_o) idx++;

    assign sdata = (idx < 14) ? cur_word[13 - idx] : 1'b0;

    // Pin activity monitors
    int rises = 0;
    int toggles = 0;
    int valid_cnt = 0;
    int bad_sck = 0;
    int lo_run = 0, hi_run = 0, last_low = 0, last_high = 0;

    always @(posedge sck_o) rises++;
    always @(sck_o) toggles++;

    always @(negedge io_clk) begin
        if (valid_o === 1'b1) valid_cnt++;
        if (cs_n_o === 1'b1 && sck_o !== 1'b1) bad_sck++;
        if (cs_n_o === 1'b0) begin
            if (hi_run != 0) last_high = hi_run;
            hi_run = 0;
            lo_run++;
        end else begin
            if (lo_run != 0) last_low = lo_run;
            lo_run = 0;
            hi_run++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_en(output int e0);
        @(negedge io_clk);
        en = 1'b1;
        @(negedge io_clk);
        e0 = cyc;
        en = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge io_clk);
            if (valid_o === 1'b1) begin
                t  = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, t, t1, t2, t3, r0, tg0, v0;
        bit ok;

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge io_clk);
        check("rst_cs_n", 32'(cs_n_o), 1);
        check("rst_sck", 32'(sck_o), 1);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_err", 32'(frame_err_o), 0);
        rst = 1'b0;
        repeat (2) @(negedge io_clk);

        // Reset asserted in the middle of a running frame
        words.push_back(14'h0777);
        pulse_en(e0);
        repeat (10) @(negedge io_clk);
        #1 rst = 1'b1;
        @(negedge io_clk);
        check("midrst_cs_n", 32'(cs_n_o), 1);
        check("midrst_sck", 32'(sck_o), 1);
        check("midrst_valid", 32'(valid_o), 0);
        check("midrst_data", 32'(data_o), 0);
        tg0 = toggles;
        repeat (5) @(negedge io_clk);
        check("midrst_no_toggle", 32'(toggles - tg0), 0);
        rst = 1'b0;
        repeat (3) @(negedge io_clk);

        // Single frame, clean leading bits
        words.push_back(14'b00_1010_0101_1100);
        r0 = rises;
        pulse_en(e0);
        wait_valid(60, t, ok);
        check("f1_seen", 32'(ok), 1);
        check("f1_latency", 32'(t - e0), 29);
        check("f1_data", 32'(data_o), 32'h0A5C);
        check("f1_err", 32'(frame_err_o), 0);
        check("f1_rises", 32'(rises - r0), 14);
        @(negedge io_clk);
        check("f1_valid_1cyc", 32'(valid_o), 0);
        check("f1_data_held", 32'(data_o), 32'h0A5C);
        repeat (5) @(negedge io_clk);
        check("f1_idle_cs_n", 32'(cs_n_o), 1);
        check("f1_cs_low", 32'(last_low), 29);

        // Nonzero leading bit
        words.push_back(14'b01_1111_1111_1111);
        pulse_en(e0);
        wait_valid(60, t, ok);
        check("f2_seen", 32'(ok), 1);
        check("f2_latency", 32'(t - e0), 29);
        check("f2_data", 32'(data_o), 32'h0FFF);
        check("f2_err", 32'(frame_err_o), 1);
        @(negedge io_clk);
        check("f2_err_1cyc", 32'(frame_err_o), 0);
        repeat (5) @(negedge io_clk);

        // Back-to-back frames with en held high
        words.push_back(14'h0000);
        words.push_back(14'h0FFF);
        words.push_back(14'h0800);
        @(negedge io_clk);
        en = 1'b1;
        wait_valid(60, t1, ok);
        check("b2b0_seen", 32'(ok), 1);
        check("b2b0_data", 32'(data_o), 32'h000);
        wait_valid(60, t2, ok);
        check("b2b1_seen", 32'(ok), 1);
        check("b2b1_data", 32'(data_o), 32'hFFF);
        wait_valid(60, t3, ok);
        en = 1'b0;
        check("b2b2_seen", 32'(ok), 1);
        check("b2b2_data", 32'(data_o), 32'h800);
        check("b2b_period_a", 32'(t2 - t1), 31);
        check("b2b_period_b", 32'(t3 - t2), 31);
        repeat (5) @(negedge io_clk);
        check("b2b_cs_low", 32'(last_low), 29);
        check("b2b_cs_high", 32'(last_high), 2);
        check("b2b_stopped", 32'(cs_n_o), 1);

        // en dropped mid-frame: frame completes, then idle
        words.push_back(14'h0123);
        v0 = valid_cnt;
        @(negedge io_clk);
        en = 1'b1;
        repeat (10) @(negedge io_clk);
        en = 1'b0;
        wait_valid(60, t, ok);
        check("drop_seen", 32'(ok), 1);
        check("drop_data", 32'(data_o), 32'h123);
        repeat (40) @(negedge io_clk);
        check("drop_one_valid", 32'(valid_cnt - v0), 1);
        check("drop_idle_cs_n", 32'(cs_n_o), 1);

        // Reset around bit 7, then a clean frame
        words.push_back(14'h0555);
        v0 = valid_cnt;
        pulse_en(e0);
        repeat (15) @(negedge io_clk);
        #1 rst = 1'b1;
        @(negedge io_clk);
        check("abort_cs_n", 32'(cs_n_o), 1);
        repeat (3) @(negedge io_clk);
        rst = 1'b0;
        repeat (40) @(negedge io_clk);
        check("abort_no_valid", 32'(valid_cnt - v0), 0);
        words.push_back(14'h0ABC);
        pulse_en(e0);
        wait_valid(60, t, ok);
        check("after_abort_seen", 32'(ok), 1);
        check("after_abort_latency", 32'(t - e0), 29);
        check("after_abort_data", 32'(data_o), 32'hABC);
        check("after_abort_err", 32'(frame_err_o), 0);
        repeat (5) @(negedge io_clk);

        check("sck_quiet_when_cs_high", 32'(bad_sck), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
